// File: rtl/beta_pkg.sv
// beta_pkg: shared constants and types for the instruction fetch unit.
package beta_pkg;
  localparam logic [31:0] DEF_RESET_VEC   = 32'h8000_0000;
  localparam logic [31:0] DEF_XADDR       = 32'h8000_0008;
  localparam logic [31:0] INST_NOP        = 32'h83FF_F800;
  localparam logic [31:0] INST_BNE_EXCEPT = 32'h77DF_0000;
  typedef enum logic [1:0] {ISSUE, FULL, FLUSH} fetch_state_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory request/acknowledge bus.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_pc_sel.sv
// fetch_pc_sel: next fetch PC priority mux (except > taken > stall > sequential).
module fetch_pc_sel
  import beta_pkg::*;
#(
  parameter logic [31:0] XADDR = DEF_XADDR
) (
  input  logic        except,
  input  logic        op_jmp,
  input  logic        op_beq,
  input  logic        op_bne,
  input  logic        zr,
  input  logic        stall,
  input  logic [31:0] fpc,
  input  logic [31:0] j_addr,
  input  logic [31:0] br_addr,
  output logic        redirect,
  output logic [31:0] npc
);
  logic taken;
  always_comb begin
    taken    = op_jmp | (op_beq & zr) | (op_bne & ~zr);
    redirect = except | taken;
    // JMP may clear the supervisor bit but never set it
    npc = except ? XADDR :
          op_jmp ? {fpc[31] & j_addr[31], j_addr[30:2], 2'b00} :
          taken  ? {br_addr[31:2], 2'b00} :
          stall  ? fpc : fpc + 32'd4;
  end
endmodule

// File: rtl/fetch.sv
// fetch: instruction fetch FSM with one-entry hold buffer and redirect flushing.
module fetch
  import beta_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] XADDR     = DEF_XADDR
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     imem,
  input  logic        stall,
  input  logic        except,
  input  logic        op_jmp,
  input  logic        op_beq,
  input  logic        op_bne,
  input  logic        zr,
  input  logic [31:0] j_addr,
  input  logic [31:0] br_addr,
  output logic [31:0] pc_out,
  output logic [31:0] ir_out,
  output logic        ir_valid
);
  fetch_state_t state_q, state_d;
  logic [31:0] fpc_q, fpc_d, addr_q, addr_d, hold_q, hold_d, pc_q, pc_d, ir_q, ir_d, npc;
  logic v_q, v_d, req_q, req_d, ack, redirect;

  fetch_pc_sel #(.XADDR(XADDR)) u_pc_sel (
    .except(except), .op_jmp(op_jmp), .op_beq(op_beq), .op_bne(op_bne), .zr(zr),
    .stall(stall), .fpc(fpc_q), .j_addr(j_addr), .br_addr(br_addr),
    .redirect(redirect), .npc(npc)
  );

  assign req_d          = ~rst & (state_q != FULL);
  assign imem.imem_req  = req_d;
  assign imem.imem_addr = addr_q;
  // an ack in the cycle a request first rises belongs to an abandoned request
  assign ack      = imem.imem_ack & req_q & (state_q != FULL);
  assign pc_out   = pc_q;
  assign ir_out   = ir_q;
  assign ir_valid = v_q;

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    hold_d  = hold_q;
    pc_d    = pc_q;
    ir_d    = stall ? ir_q : INST_NOP;
    v_d     = v_q & stall;
    if (redirect) begin
      fpc_d   = npc;
      ir_d    = INST_NOP;
      v_d     = 1'b0;
      state_d = (state_q != FULL && !ack) ? FLUSH : ISSUE;
    end else if (state_q == ISSUE && ack && stall) begin
      hold_d  = imem.imem_rdata;
      state_d = FULL;
    end else if ((state_q == ISSUE && ack) || (state_q == FULL && !stall)) begin
      ir_d    = (state_q == FULL) ? hold_q : imem.imem_rdata;
      pc_d    = npc;
      v_d     = 1'b1;
      fpc_d   = npc;
      state_d = ISSUE;
    end else if (state_q == FLUSH && ack) begin
      state_d = ISSUE;
    end
    addr_d = (state_d == ISSUE) ? fpc_d : addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ISSUE;
      fpc_q   <= RESET_VEC;
      addr_q  <= RESET_VEC;
      hold_q  <= '0;
      pc_q    <= '0;
      ir_q    <= INST_NOP;
      v_q     <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      v_q     <= v_d;
      req_q   <= req_d;
    end
  end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: randomized and directed checks of fetch against an instruction-stream reference model.
module tb_fetch;
  import beta_pkg::*;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, except = 1'b0;
  logic op_jmp = 1'b0, op_beq = 1'b0, op_bne = 1'b0, zr = 1'b0;
  logic [31:0] j_addr = '0, br_addr = '0, pc_out, ir_out;
  logic ir_valid;
  fetch_if bus();

  fetch dut (
    .clk(clk), .rst(rst), .imem(bus), .stall(stall), .except(except),
    .op_jmp(op_jmp), .op_beq(op_beq), .op_bne(op_bne), .zr(zr),
    .j_addr(j_addr), .br_addr(br_addr), .pc_out(pc_out), .ir_out(ir_out), .ir_valid(ir_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cnt = 0, nreq = 0, idle = 0, lat_lo = 1, lat_hi = 1;
  logic [31:0] exp_pc = DEF_RESET_VEC, maddr = '0, last_addr = '0, pir = '0, ppc = '0;
  logic exp_v = 1'b0, pv = 1'b0, pend = 1'b0, late = 1'b0, stale = 1'b0, held = 1'b0;
  logic rst_p = 1'b1, stall_p = 1'b0, redir_p = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a == 32'h8000_0000 ? 32'hAAAA_0001 :
           a == 32'h8000_0004 ? 32'hAAAA_0002 : (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // one clock: check what the last edge produced, drive inputs and memory, advance the model
  task automatic step(input logic r, s, ex, jm, bq, bn, z, input logic [31:0] ja, ba);
    logic ack, acc, tk;
    logic [31:0] rd;
    @(negedge clk);
    if (rst_p) begin
      chk("rst_valid", ir_valid, 0);
      chk("rst_ir", ir_out, INST_NOP);
      chk("rst_pc", pc_out, 0);
    end else if (stall_p && !redir_p) begin
      chk("hold_valid", ir_valid, pv);
      chk("hold_ir", ir_out, pir);
      chk("hold_pc", pc_out, ppc);
    end else begin
      chk("valid", ir_valid, exp_v);
      if (exp_v) begin
        chk("ir", ir_out, memf(exp_pc));
        chk("pc_out", pc_out, exp_pc + 32'd4);
        exp_pc += 32'd4;
        idle = 0;
      end else chk("nop", ir_out, INST_NOP);
    end
    if (held) chk("full_req", bus.imem_req, 0);
    chk("progress", idle > 24, 0);
    if (idle > 24) idle = 0;
    pv = ir_valid; pir = ir_out; ppc = pc_out;
    rst = r; stall = s; except = ex; op_jmp = jm; op_beq = bq; op_bne = bn; zr = z;
    j_addr = ja; br_addr = ba;
    #1;
    ack = 1'b0; acc = 1'b0; rd = '0;
    tk = jm | (bq & z) | (bn & ~z);
    if (r) begin
      chk("rst_req", bus.imem_req, 0);
      late = late | pend; pend = 0; stale = 0; held = 0;
      exp_pc = DEF_RESET_VEC; exp_v = 0; idle = 0;
    end else begin
      if (!s) idle++;
      if (pend) begin
        chk("req_hold", bus.imem_req, 1);
        chk("addr_hold", bus.imem_addr, maddr);
      end else if (bus.imem_req) begin
        pend = 1; maddr = bus.imem_addr; cnt = $urandom_range(lat_hi, lat_lo);
        nreq++; last_addr = bus.imem_addr;
        chk("req_addr", bus.imem_addr, exp_pc);
      end
      ack = late | (pend && cnt == 0);
      rd  = late ? 32'hDEAD_BEEF : memf(maddr);
      acc = pend && cnt == 0 && !stale && !(ex | tk);
      if (pend && cnt == 0) begin pend = 0; stale = 0; end
      else if (pend) cnt--;
      late = 0;
      if (ex | tk) begin
        exp_pc = ex ? DEF_XADDR : jm ? {exp_pc[31] & ja[31], ja[30:2], 2'b00} : {ba[31:2], 2'b00};
        exp_v = 0; held = 0; idle = 0; stale = stale | pend;
      end else if (s) held = held | acc;
      else begin exp_v = acc | held; held = 0; end
    end
    bus.imem_ack = ack; bus.imem_rdata = rd;
    rst_p = r; stall_p = s; redir_p = !r && (ex | tk);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic wait_req(input string tag);
    int n0 = nreq;
    for (int i = 0; i < 16 && nreq == n0; i++) idle_step();
    chk(tag, nreq != n0, 1);
  endtask

  initial begin
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, '0, '0);
    wait_req("seen_first");
    chk("first_addr", last_addr, 32'h8000_0000);
    wait_req("seen_second");
    chk("second_addr", last_addr, 32'h8000_0004);
    for (int i = 0; i < 3; i++) idle_step();
    wait_req("seen_pre_stall");
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, '0, '0);
    chk("stall_req_low", bus.imem_req, 0);
    for (int i = 0; i < 4; i++) idle_step();
    lat_lo = 3; lat_hi = 3;
    wait_req("seen_pre_beq");
    step(0, 0, 0, 0, 1, 0, 1, '0, 32'h8000_0100);
    wait_req("seen_beq");
    chk("beq_target", last_addr, 32'h8000_0100);
    step(0, 0, 0, 0, 1, 0, 0, '0, 32'h8000_0100);
    wait_req("seen_beq_nt");
    chk("beq_not_taken", last_addr, 32'h8000_0104);
    step(0, 0, 0, 1, 0, 0, 0, 32'h0000_0043, '0);
    wait_req("seen_jmp1");
    chk("jmp_super", last_addr, 32'h0000_0040);
    step(0, 0, 0, 1, 0, 0, 0, 32'h8000_0040, '0);
    wait_req("seen_jmp2");
    chk("jmp_user", last_addr, 32'h0000_0040);
    step(0, 0, 1, 1, 0, 0, 0, 32'h0000_0100, '0);
    wait_req("seen_exc");
    chk("exc_prio", last_addr, 32'h8000_0008);
    step(0, 1, 1, 0, 0, 0, 0, '0, '0);
    wait_req("seen_exc_stall");
    chk("exc_stall", last_addr, 32'h8000_0008);
    step(0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, '0);
    wait_req("seen_top");
    chk("top_addr", last_addr, 32'hFFFF_FFFC);
    wait_req("seen_wrap");
    chk("wrap_addr", last_addr, 32'h0000_0000);
    wait_req("seen_pre_rst");
    step(1, 0, 0, 0, 0, 0, 0, '0, '0);
    step(1, 0, 0, 0, 0, 0, 0, '0, '0);
    wait_req("seen_post_rst");
    chk("rst_restart", last_addr, 32'h8000_0000);
    for (int i = 0; i < 8; i++) idle_step();
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4,
           1'($urandom_range(0, 1)), $urandom, $urandom);
    for (int i = 0; i < 10; i++) idle_step();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_VEC, default 32'h8000_0000, the PC of the first fetch after reset.
REQ-002 Parameter XADDR, default 32'h8000_0008, the exception vector.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 imem_req  out  1  instruction memory read request; held high until imem_ack.
REQ-006 imem_addr  out  32  word address of the request; bits [1:0] always 2'b00.
REQ-007 imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle; arrives at least 1 cycle after imem_req rises.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 stall  in  1  decode cannot accept a new instruction; hold pc_out/ir_out/ir_valid.
REQ-010 except  in  1  redirect to XADDR.
REQ-011 op_jmp, op_beq, op_bne  in  1 each  control-flow opcode flags from decode.
REQ-012 zr  in  1  decode register operand equals zero.
REQ-013 j_addr, br_addr  in  32 each  jump and branch targets from decode.
REQ-014 pc_out  out  32  PC+4 of the instruction on ir_out.
REQ-015 ir_out  out  32  instruction to decode; INST_NOP when ir_valid is low.
REQ-016 ir_valid  out  1  ir_out holds a real fetched instruction.

Function
REQ-017 taken = op_jmp | (op_beq & zr) | (op_bne & ~zr).
REQ-018 The JMP target is {fpc[31] & j_addr[31], j_addr[30:2], 2'b00}, so supervisor mode is never gained by JMP.
REQ-019 The BEQ/BNE target is {br_addr[31:2], 2'b00}.
REQ-020 Redirect priority: rst > except > taken > stall > sequential (fpc+4).
REQ-021 Arithmetic on fpc is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-022 States are ISSUE (request outstanding or issuing), FULL (an instruction is acked but blocked by stall) and FLUSH (an outstanding request must be discarded).
REQ-023 ISSUE with ack, no stall and no redirect: present ir_out=imem_rdata, pc_out=fpc+4, ir_valid=1 next cycle; fpc+=4; the next request issues that cycle; stay in ISSUE.
REQ-024 ISSUE with ack and stall: capture the word into a 1-entry hold buffer, drop imem_req, go to FULL.
REQ-025 FULL with stall low: present the buffer, fpc+=4, go to ISSUE.
REQ-026 On redirect while in ISSUE without ack: load fpc with the target, ir_valid=0 next cycle, go to FLUSH.
REQ-027 FLUSH: keep imem_req high at the old address, drop the first ack's data, then issue at the new fpc and go to ISSUE.
REQ-028 A redirect in the same cycle as an ack drops that ack's data; fpc takes the target; stay in ISSUE.
REQ-029 A redirect in FULL drops the buffer and goes to ISSUE at the target.
REQ-030 A redirect always produces exactly one annulled slot (ir_valid=0, ir_out=INST_NOP), even when stall is high.
REQ-031 While stall is high and no redirect occurs, pc_out, ir_out and ir_valid are unchanged.
REQ-032 imem_addr is unchanged while imem_req is high and no ack has arrived.

Reset
REQ-033 During rst: imem_req=0, ir_valid=0, ir_out=INST_NOP, pc_out=0, state=ISSUE, fpc=RESET_VEC, hold buffer invalid.
REQ-034 The first request issues in the cycle after rst deasserts, with imem_addr=RESET_VEC.
REQ-035 rst mid-transaction abandons the outstanding request; a late ack after reset is ignored until the new request issues.

Structure
REQ-036 Shared package beta_pkg holds RESET_VEC and XADDR defaults, INST_NOP, INST_BNE_EXCEPT, and the fetch_state_t enum (ISSUE, FULL, FLUSH).
REQ-037 One sub-module, fetch_pc_sel, holds the combinational target/priority mux of REQ-017 to REQ-021; the FSM, fpc and hold buffer stay in fetch.

Verification
REQ-038 Reset release, 1-cycle ack memory, words 0xAAAA0001, 0xAAAA0002 -> imem_addr 0x80000000 then 0x80000004; ir_out in order with pc_out 0x80000004 and 0x80000008.
REQ-039 stall high for 3 cycles while an ack arrives -> ir_out held, imem_req low in FULL, buffered word presented with pc_out+4 the cycle after stall drops, no word lost or duplicated.
REQ-040 op_beq=1, zr=1, br_addr=0x80000100 while a request is outstanding -> one NOP slot, stale ack dropped, next imem_addr=0x80000100; with zr=0 -> sequential fetch.
REQ-041 op_jmp=1, j_addr=0x80000040 with fpc[31]=0 -> target 0x00000040; op_jmp=1, j_addr=0x00000043 with fpc[31]=1 -> target 0x00000040.
REQ-042 except and taken in the same cycle -> fetch from 0x80000008; except with stall high -> redirect still taken.
REQ-043 fpc=0xFFFFFFFC, sequential fetch -> next imem_addr=0x00000000; rst pulsed mid-request -> late ack ignored, fetch restarts at 0x80000000.
